rr_burst_arbiter: RTL
=====================

Name: rr_burst_arbiter

Overview:
- Registered N-port arbiter granting one requester at a time to a shared downstream resource (e.g. unified buffer or weight FIFO port) in the TPU control path.
- Supports fixed-priority and round-robin modes.
- Holds a grant across a multi-beat burst until the requester signals last.
- Bounds every burst with a beat counter so no port can starve the others.

Parameters:
- NUM_PORTS, 8, number of requesters (2..32).
- MODE, ARB_RR, arbitration mode from arb_pkg: ARB_FIXED (index 0 highest priority) or ARB_RR (rotating).
- MAX_BURST, 16, maximum beats per grant before forced release (1..255).

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- requests  in  NUM_PORTS  per-port request level; held high for the whole burst.
- last  in  NUM_PORTS  per-port end-of-burst flag, qualified by a beat on that port.
- ready  in  1  downstream accepts a beat this cycle.
- grants  out  NUM_PORTS  registered one-hot grant; all-zero when idle.
- grant_valid  out  1  equals |grants.
- grant_idx  out  $clog2(NUM_PORTS)  binary index of the granted port; 0 when idle.
- beat  out  1  grant_valid & requests[grant_idx] & ready.

Behaviour:
- Reset (async assert, sync deassert in the reset tree):
  - grants=0, grant_valid=0, grant_idx=0, beat_cnt=0.
  - RR pointer=0, so port 0 has highest priority first.
- States:
  - IDLE (no grant).
  - BUSY (grant held).
- IDLE, requests != 0:
  - Arbitrate; winner's grant registered at the next edge.
  - Latency is 1 cycle from request to grant.
- Winner selection:
  - ARB_FIXED: lowest set index.
  - ARB_RR: first set bit at or above pointer, wrapping to 0.
  - On every new grant, pointer <= winner+1 mod NUM_PORTS. Pointer stays 0 in ARB_FIXED.
- BUSY, each beat: beat_cnt++.
- Release conditions, all evaluated in the same cycle:
  - (a) beat with last[grant_idx]=1.
  - (b) beat with beat_cnt==MAX_BURST-1 (forced release).
  - (c) requests[grant_idx]=0 (withdrawal; no beat counted).
- On release:
  - Re-arbitrate in the same cycle using the already-advanced pointer.
  - If any request remains, the new grant appears at the next edge with no idle bubble. Otherwise go to IDLE.
  - beat_cnt <= 0.
- RR re-arbitration may re-grant the releasing port only if no other port requests.
- last on non-granted ports is ignored.
- last without ready does not release.
- ready low: grant holds indefinitely; beat_cnt frozen.
- New requests arriving while BUSY never preempt the current grant.
- MAX_BURST=1: every beat releases, giving single-beat round robin.
- Invariants (must be assertable):
  - $onehot0(grants).
  - grants & ~requests may be nonzero for at most the one cycle following a withdrawal.
  - grant_idx is consistent with grants.
- Reset mid-burst: outputs clear immediately and asynchronously; the burst is abandoned.

Decomposition:
- arb_pkg holds:
  - typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e.
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e.
  - function onehot_to_idx.
- Sub-module arb_priority_pick: combinational, parametrised NUM_PORTS; inputs requests and pointer, output one-hot winner.
  - Implemented as the double-width masked priority encoder.
  - Instantiated once.
  - Pointer tied to 0 for ARB_FIXED.
- Top level holds the FSM, pointer, beat counter and output registers.

Test Plan:
- Reset then requests=8'b1010_0100, ARB_RR, ready=1, last=1 each beat -> grants at cycles 1,2,3 are 0000_0100, 0010_0000, 1000_0000, then 0000_0100 again.
- ARB_FIXED, requests=8'hFF held, last=1 every beat -> grants stays 0000_0001 every cycle; no other port is served.
- MAX_BURST=4, port 3 alone requesting with last=0, ready=1 -> forced release after 4 beats. Port 3 regranted with beat_cnt back at 0. With port 5 also requesting, port 5 is granted on the cycle after the 4th beat.
- Port 2 granted, ready=0 for 10 cycles while port 6 requests -> grants stays 0000_0100 and beat_cnt=0. Then ready=1 with last -> port 6 granted next cycle.
- Port 1 granted mid-burst, drops requests[1] -> grants=0 next cycle if no other requests. With port 7 requesting, grants=1000_0000 next cycle.
- Assert rst_n=0 mid-burst asynchronously -> grants=0 before the next edge. After release, the first grant goes to the lowest requesting index (pointer=0).
- Random 10k cycles, both modes -> onehot0 and no-preemption assertions hold. In RR mode no requesting port waits more than (NUM_PORTS-1)*MAX_BURST beats.

Source files
------------

// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and helpers for the burst arbiter: arbitration mode, FSM state,
// beat-counter width and a one-hot to binary index converter.
package arb_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  // Wide enough for MAX_BURST up to 255.
  localparam int CNT_W = 8;

  // OR-reduction of set positions; exact for one-hot or all-zero inputs.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Requester/arbiter bundle. master = requester side, slave = arbiter side.
interface rr_burst_arbiter_if #(
  parameter int NUM_PORTS = 8
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  // Handshake: a beat transfers on any cycle where grant_valid, the granted
  // port's request and ready are all high; last is only sampled on such a beat.
  logic [NUM_PORTS-1:0] requests;
  logic [NUM_PORTS-1:0] last;
  logic                 ready;
  logic [NUM_PORTS-1:0] grants;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;
  logic                 beat;

  modport master (
    output requests, last, ready,
    input  grants, grant_valid, grant_idx, beat
  );

  modport slave (
    input  requests, last, ready,
    output grants, grant_valid, grant_idx, beat
  );
endinterface

// File: rtl/rr_burst_arbiter_pick.sv
// Combinational rotating priority pick: first request at or above pointer,
// wrapping to 0, via a double-width masked lowest-set-bit isolate.
module arb_priority_pick #(
  parameter int NUM_PORTS = 8
) (
  input  logic [NUM_PORTS-1:0]         requests,
  input  logic [$clog2(NUM_PORTS)-1:0] pointer,
  output logic [NUM_PORTS-1:0]         winner
);
  logic [NUM_PORTS-1:0]   mask;
  logic [2*NUM_PORTS-1:0] dbl;
  logic [2*NUM_PORTS-1:0] iso;

  always_comb begin
    mask   = '1 << pointer;
    // Lower half sees only ports at/above pointer; upper half supplies the wrap.
    dbl    = {requests, requests & mask};
    iso    = dbl & (-dbl);
    winner = iso[NUM_PORTS-1:0] | iso[2*NUM_PORTS-1:NUM_PORTS];
  end
endmodule

// File: rtl/rr_burst_arbiter.sv
// Registered N-port burst arbiter: holds a grant until last, a forced release
// at MAX_BURST beats, or request withdrawal, then re-arbitrates with no bubble.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int        NUM_PORTS = 8,
  parameter arb_mode_e MODE      = ARB_RR,
  parameter int        MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_burst_arbiter_if.slave bus,
  output arb_state_e       state_dbg,
  output logic [CNT_W-1:0] beat_cnt_dbg
);
  localparam int               IDX_W     = $clog2(NUM_PORTS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grants_q, grants_d, winner;
  logic [IDX_W-1:0]     ptr_q, ptr_d, pick_ptr, gidx, widx;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 beat, rearb;

  assign gidx     = IDX_W'(onehot_to_idx(32'(grants_q)));
  assign widx     = IDX_W'(onehot_to_idx(32'(winner)));
  assign pick_ptr = (MODE == ARB_FIXED) ? '0 : ptr_q;
  assign beat     = (|grants_q) & bus.requests[gidx] & bus.ready;

  arb_priority_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .requests (bus.requests),
    .pointer  (pick_ptr),
    .winner   (winner)
  );

  always_comb begin
    state_d  = state_q;
    grants_d = grants_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rearb    = 1'b0;
    case (state_q)
      ARB_IDLE: rearb = 1'b1;
      ARB_BUSY: begin
        if (!bus.requests[gidx]) rearb = 1'b1;
        else if (beat && (bus.last[gidx] || cnt_q == LAST_BEAT)) rearb = 1'b1;
        else if (beat) cnt_d = cnt_q + 1'b1;
      end
      default: rearb = 1'b1;
    endcase
    // Pointer already sits past the releasing port, so it is picked last.
    if (rearb) begin
      cnt_d    = '0;
      grants_d = winner;
      state_d  = (|winner) ? ARB_BUSY : ARB_IDLE;
      if (MODE == ARB_RR && (|winner))
        ptr_d = (widx == IDX_W'(NUM_PORTS - 1)) ? '0 : widx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      grants_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grants_q <= grants_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.grants      = grants_q;
  assign bus.grant_valid = |grants_q;
  assign bus.grant_idx   = gidx;
  assign bus.beat        = beat;
  assign state_dbg       = state_q;
  assign beat_cnt_dbg    = cnt_q;
endmodule
